// File: rtl/tjmono2_tx_emu_if.sv
// Word-input handshake between a hit-word source and the TJ-Monopix2 TX emulator.
interface tjmono2_tx_emu_if;
   logic        ENABLE;
   logic [31:0] DATA_IN;
   logic        DATA_VALID;
   logic        DATA_READY;

   modport master (output ENABLE, output DATA_IN, output DATA_VALID, input DATA_READY);
   modport slave  (input ENABLE, input DATA_IN, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/tjmono2_tx_emu.sv
// TJ-Monopix2 chip-side transmitter emulator: frames 32-bit hit words as
// K28.1, four 8b10b data bytes (MSB first), K28.3, with K28.5 commas on the
// idle line; one serial bit per BUS_CLK, each symbol sent LSB (bit a) first.
module tjmono2_tx_emu #(
   parameter int unsigned IDLE_MIN      = 2,
   parameter bit          INVERT_OUTPUT = 1'b0
) (
   input  logic            BUS_CLK,
   input  logic            BUS_RST,
   tjmono2_tx_emu_if.slave bus,
   output logic            TX_DATA,
   output logic            BUSY,
   output logic [15:0]     WORD_CNT
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SOF, ST_D3, ST_D2, ST_D1, ST_D0, ST_EOF
   } state_t;

   // Symbols written in abcdeifghj order, bit a at the MSB.
   localparam logic [9:0] K28_5_N = 10'b0011111010;
   localparam logic [9:0] K28_5_P = 10'b1100000101;
   localparam logic [9:0] K28_1_N = 10'b0011111001;
   localparam logic [9:0] K28_1_P = 10'b1100000110;
   localparam logic [9:0] K28_3_N = 10'b0011110011;
   localparam logic [9:0] K28_3_P = 10'b1100001100;

   localparam logic [3:0] IDLE_MIN_C = 4'(IDLE_MIN);

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]  idle_cnt_q, idle_cnt_d;
   logic [9:0]  sr_q, sr_d;
   logic        rd_q, rd_d;        // disparity at the start of the symbol in flight (1 = RD+)
   logic        unbal_q, unbal_d;  // symbol in flight flips the disparity
   logic        busy_q, busy_d;
   logic [31:0] data_q, data_d;
   logic [15:0] word_cnt_q, word_cnt_d;

   logic        boundary;
   logic        ready;
   logic        accept;
   logic        rd_cur;
   logic [9:0]  sym;

   // 5b/6b table, RD- column (abcdei, a at MSB)
   function automatic logic [5:0] tbl6(input logic [4:0] x);
      case (x)
         5'd0:  tbl6 = 6'b100111;  5'd1:  tbl6 = 6'b011101;
         5'd2:  tbl6 = 6'b101101;  5'd3:  tbl6 = 6'b110001;
         5'd4:  tbl6 = 6'b110101;  5'd5:  tbl6 = 6'b101001;
         5'd6:  tbl6 = 6'b011001;  5'd7:  tbl6 = 6'b111000;
         5'd8:  tbl6 = 6'b111001;  5'd9:  tbl6 = 6'b100101;
         5'd10: tbl6 = 6'b010101;  5'd11: tbl6 = 6'b110100;
         5'd12: tbl6 = 6'b001101;  5'd13: tbl6 = 6'b101100;
         5'd14: tbl6 = 6'b011100;  5'd15: tbl6 = 6'b010111;
         5'd16: tbl6 = 6'b011011;  5'd17: tbl6 = 6'b100011;
         5'd18: tbl6 = 6'b010011;  5'd19: tbl6 = 6'b110010;
         5'd20: tbl6 = 6'b001011;  5'd21: tbl6 = 6'b101010;
         5'd22: tbl6 = 6'b011010;  5'd23: tbl6 = 6'b111010;
         5'd24: tbl6 = 6'b110011;  5'd25: tbl6 = 6'b100110;
         5'd26: tbl6 = 6'b010110;  5'd27: tbl6 = 6'b110110;
         5'd28: tbl6 = 6'b001110;  5'd29: tbl6 = 6'b101110;
         5'd30: tbl6 = 6'b011110;  default: tbl6 = 6'b101011;
      endcase
   endfunction

   // 3b/4b table, RD- column (fghj, f at MSB); y=7 is the primary P7 code
   function automatic logic [3:0] tbl4(input logic [2:0] y);
      case (y)
         3'd0: tbl4 = 4'b1011;  3'd1: tbl4 = 4'b1001;
         3'd2: tbl4 = 4'b0101;  3'd3: tbl4 = 4'b1100;
         3'd4: tbl4 = 4'b1101;  3'd5: tbl4 = 4'b1010;
         3'd6: tbl4 = 4'b0110;  default: tbl4 = 4'b1110;
      endcase
   endfunction

   // Data byte encoder; rd = 1 means RD+ entering the symbol
   function automatic logic [9:0] enc_data(input logic [7:0] d, input logic rd);
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] c6;
      logic [3:0] c4;
      logic       rd6;
      x  = d[4:0];
      y  = d[7:5];
      c6 = tbl6(x);
      if (rd && (($countones(c6) != 3) || (x == 5'd7)))
         c6 = ~c6;
      rd6 = ($countones(c6) == 3) ? rd : ~rd;
      if ((y == 3'd7) &&
          ((!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
           ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)))))
         c4 = 4'b0111;
      else
         c4 = tbl4(y);
      if (rd6 && (($countones(c4) != 2) || (y == 3'd3)))
         c4 = ~c4;
      return {c6, c4};
   endfunction

   assign boundary       = (bit_cnt_q == 4'd9);
   assign ready          = boundary && (state_q == ST_IDLE) && (idle_cnt_q >= IDLE_MIN_C) && bus.ENABLE;
   assign accept         = ready && bus.DATA_VALID;
   // The reset value of sr_q is already a K28.5 RD- in flight, so the disparity
   // for the next symbol is the in-flight start disparity flipped if unbalanced.
   assign rd_cur         = rd_q ^ unbal_q;
   assign bus.DATA_READY = ready;

   // Framing FSM, symbol selection, shifter and disparity next-state
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      busy_d     = busy_q;
      data_d     = data_q;
      word_cnt_d = word_cnt_q;
      sym        = rd_cur ? K28_5_P : K28_5_N;
      bit_cnt_d  = boundary ? 4'd0 : bit_cnt_q + 4'd1;
      sr_d       = {1'b0, sr_q[9:1]};
      rd_d       = rd_q;
      unbal_d    = unbal_q;
      if (boundary) begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  sym        = rd_cur ? K28_1_P : K28_1_N;
                  state_d    = ST_D3;
                  data_d     = bus.DATA_IN;
                  word_cnt_d = word_cnt_q + 16'd1;
                  busy_d     = 1'b1;
               end else begin
                  busy_d = 1'b0;
                  if (idle_cnt_q < IDLE_MIN_C)
                     idle_cnt_d = idle_cnt_q + 4'd1;
               end
            end
            ST_SOF: begin
               sym     = rd_cur ? K28_1_P : K28_1_N;
               state_d = ST_D3;
            end
            ST_D3: begin
               sym     = enc_data(data_q[31:24], rd_cur);
               state_d = ST_D2;
            end
            ST_D2: begin
               sym     = enc_data(data_q[23:16], rd_cur);
               state_d = ST_D1;
            end
            ST_D1: begin
               sym     = enc_data(data_q[15:8], rd_cur);
               state_d = ST_D0;
            end
            ST_D0: begin
               sym     = enc_data(data_q[7:0], rd_cur);
               state_d = ST_EOF;
            end
            ST_EOF: begin
               sym        = rd_cur ? K28_3_P : K28_3_N;
               idle_cnt_d = '0;
               state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
         sr_d    = {<<{sym}};
         rd_d    = rd_cur;
         unbal_d = ($countones(sym) != 5);
      end
   end

   // State registers; reset restarts the line with a K28.5 RD- in flight
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         idle_cnt_q <= '0;
         sr_q       <= {<<{K28_5_N}};
         rd_q       <= 1'b0;
         unbal_q    <= 1'b1;
         busy_q     <= 1'b0;
         data_q     <= '0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         sr_q       <= sr_d;
         rd_q       <= rd_d;
         unbal_q    <= unbal_d;
         busy_q     <= busy_d;
         data_q     <= data_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign TX_DATA  = sr_q[0] ^ INVERT_OUTPUT;
   assign BUSY     = busy_q;
   assign WORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_tjmono2_tx_emu.sv
// Scoreboard bench for tjmono2_tx_emu: stimulus pushes hand-encoded frame
// symbols; a monitor deserialises TX_DATA, checks disparity and pops/compares
// every non-comma symbol. A second, inverted instance runs in lockstep.
module tb_tjmono2_tx_emu;

   localparam logic [9:0] SOF_P = 10'b1100000110;
   localparam logic [9:0] SOF_N = 10'b0011111001;
   localparam logic [9:0] EOF_P = 10'b1100001100;
   localparam logic [9:0] EOF_N = 10'b0011110011;
   localparam logic [9:0] K5_N  = 10'b0011111010;
   localparam logic [9:0] K5_P  = 10'b1100000101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx, busy, tx_inv, busy_inv;
   logic [15:0] wcnt, wcnt_inv;
   int          cyc;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [9:0]  expq[$];

   tjmono2_tx_emu_if bus ();
   tjmono2_tx_emu_if bus_inv ();

   assign bus_inv.ENABLE     = bus.ENABLE;
   assign bus_inv.DATA_IN    = bus.DATA_IN;
   assign bus_inv.DATA_VALID = bus.DATA_VALID;

   tjmono2_tx_emu #(.IDLE_MIN(2), .INVERT_OUTPUT(1'b0)) dut (
      .BUS_CLK(clk), .BUS_RST(rst), .bus(bus),
      .TX_DATA(tx), .BUSY(busy), .WORD_CNT(wcnt)
   );

   tjmono2_tx_emu #(.IDLE_MIN(2), .INVERT_OUTPUT(1'b1)) dut_inv (
      .BUS_CLK(clk), .BUS_RST(rst), .bus(bus_inv),
      .TX_DATA(tx_inv), .BUSY(busy_inv), .WORD_CNT(wcnt_inv)
   );

   always #5 clk = ~clk;

   // cycle index since reset release; cycle 0 shows bit a of the reset comma
   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t cyc=%0d)", nm, act, exp, $time, cyc);
      end
   endtask

   task automatic push6(input logic [9:0] s0, s1, s2, s3, s4, s5);
      expq.push_back(s0); expq.push_back(s1); expq.push_back(s2);
      expq.push_back(s3); expq.push_back(s4); expq.push_back(s5);
   endtask

   task automatic do_reset();
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
   endtask

   task automatic goto_cycle(input int n);
      for (int i = 0; i < 2000 && cyc < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_ready(input string nm, output int at);
      bit seen;
      seen = 1'b0;
      at   = -1;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (bus.DATA_READY) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: DATA_READY never seen within 300 cycles, expected a pulse", nm);
      end
   endtask

   // Monitor: deserialise, disparity check, scoreboard compare, inversion check
   logic [9:0] msym;
   int         mbits;
   logic       mrd;
   always @(negedge clk) begin
      logic       inv_exp;
      logic       ok;
      logic [9:0] e;
      int         ones;
      if (rst) begin
         mbits = 0;
         mrd   = 1'b0;
         msym  = '0;
      end else begin
         inv_exp = ~tx;
         check("inverted TX_DATA", {31'd0, tx_inv}, {31'd0, inv_exp});
         check("inverted BUSY", {31'd0, busy_inv}, {31'd0, busy});
         msym = {msym[8:0], tx};
         mbits++;
         if (mbits == 10) begin
            mbits = 0;
            ones  = $countones(msym);
            ok    = (ones == 5) || (ones == 6 && !mrd) || (ones == 4 && mrd);
            check("running disparity", {31'd0, ok}, 32'd1);
            if (ones != 5) mrd = ~mrd;
            if (msym != K5_N && msym != K5_P) begin
               if (expq.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected symbol: got %b, expected K28.5 comma", msym);
               end else begin
                  e = expq.pop_front();
                  check("frame symbol", {22'd0, msym}, {22'd0, e});
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: run exceeded time limit, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] pat;
      logic [31:0] w3 [3];
      int          at, bcnt, bfirst;
      bit          rdy_seen;

      pat   = {K5_N, K5_P};
      w3[0] = 32'h00000000;
      w3[1] = 32'hFFFFFFFF;
      w3[2] = 32'h12345678;
      bus.ENABLE     = 1'b0;
      bus.DATA_IN    = '0;
      bus.DATA_VALID = 1'b0;

      // reset state and idle comma stream with ENABLE low
      do_reset();
      check("reset TX_DATA", {31'd0, tx}, 32'd0);
      check("reset TX_DATA inverted", {31'd0, tx_inv}, 32'd1);
      check("reset BUSY", {31'd0, busy}, 32'd0);
      check("reset WORD_CNT", {16'd0, wcnt}, 32'd0);
      check("reset DATA_READY", {31'd0, bus.DATA_READY}, 32'd0);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         check("idle comma bit", {31'd0, tx}, {31'd0, pat[19 - (cyc % 20)]});
         check("no DATA_READY while disabled", {31'd0, bus.DATA_READY}, 32'd0);
      end
      check("idle WORD_CNT", {16'd0, wcnt}, 32'd0);

      // single word 0xDEADBEEF
      do_reset();
      bus.ENABLE     = 1'b1;
      bus.DATA_IN    = 32'hDEADBEEF;
      bus.DATA_VALID = 1'b1;
      push6(SOF_P, 10'b0111100110, 10'b1011001010, 10'b1000011010, 10'b0101110001, EOF_N);
      wait_ready("first DATA_READY", at);
      check("first accept cycle", at, 32'd29);
      @(posedge clk); #1 bus.DATA_VALID = 1'b0;
      bcnt   = 0;
      bfirst = -1;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (busy) begin
            if (bfirst < 0) bfirst = cyc;
            bcnt++;
         end
      end
      check("BUSY length", bcnt, 32'd60);
      check("BUSY first cycle", bfirst, 32'd30);
      check("single WORD_CNT", {16'd0, wcnt}, 32'd1);
      check("single frame drained", expq.size(), 32'd0);

      // three back-to-back words with DATA_VALID held
      do_reset();
      bus.DATA_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.DATA_IN = w3[i];
         case (i)
            0: push6(SOF_P, 10'b1001110100, 10'b1001110100, 10'b1001110100, 10'b1001110100, EOF_N);
            1: push6(SOF_P, 10'b1010110001, 10'b1010110001, 10'b1010110001, 10'b1010110001, EOF_N);
            default: push6(SOF_P, 10'b0100111011, 10'b0010111001, 10'b0110100101, 10'b0011001100, EOF_N);
         endcase
         wait_ready("back-to-back DATA_READY", at);
         check("back-to-back accept cycle", at, 29 + 80 * i);
         @(posedge clk); #1;
      end
      bus.DATA_VALID = 1'b0;
      goto_cycle(260);
      check("back-to-back WORD_CNT", {16'd0, wcnt}, 32'd3);
      check("back-to-back drained", expq.size(), 32'd0);

      // ENABLE dropped during D2; A7 alternates in the first frame
      do_reset();
      bus.DATA_IN    = 32'hF1EB0000;
      bus.DATA_VALID = 1'b1;
      push6(SOF_P, 10'b1000110111, 10'b1101001000, 10'b1001110100, 10'b1001110100, EOF_N);
      wait_ready("enable test DATA_READY", at);
      check("enable test accept cycle", at, 32'd29);
      @(posedge clk); #1 bus.DATA_IN = 32'h00000000;
      push6(SOF_N, 10'b0110001011, 10'b0110001011, 10'b0110001011, 10'b0110001011, EOF_P);
      goto_cycle(55);
      bus.ENABLE = 1'b0;
      rdy_seen = 1'b0;
      for (int k = 0; k < 95; k++) begin
         @(negedge clk);
         if (bus.DATA_READY) rdy_seen = 1'b1;
         if (k == 35) check("BUSY while ENABLE low", {31'd0, busy}, 32'd0);
         if (k == 20) check("frame continues with ENABLE low", {31'd0, busy}, 32'd1);
      end
      check("DATA_READY while ENABLE low", {31'd0, rdy_seen}, 32'd0);
      goto_cycle(150);
      bus.ENABLE = 1'b1;
      wait_ready("re-enable DATA_READY", at);
      check("re-enable accept cycle", at, 32'd159);
      @(posedge clk); #1 bus.DATA_VALID = 1'b0;
      goto_cycle(230);
      check("enable test WORD_CNT", {16'd0, wcnt}, 32'd2);
      check("enable test drained", expq.size(), 32'd0);

      // asynchronous reset in the middle of D1
      do_reset();
      bus.DATA_IN    = 32'hDEADBEEF;
      bus.DATA_VALID = 1'b1;
      push6(SOF_P, 10'b0111100110, 10'b1011001010, 10'b1000011010, 10'b0101110001, EOF_N);
      wait_ready("pre-reset DATA_READY", at);
      @(posedge clk); #1 bus.DATA_VALID = 1'b0;
      goto_cycle(64);
      #2 rst = 1'b1;
      #1;
      check("mid-frame reset TX_DATA", {31'd0, tx}, 32'd0);
      check("mid-frame reset BUSY", {31'd0, busy}, 32'd0);
      check("mid-frame reset WORD_CNT", {16'd0, wcnt}, 32'd0);
      expq.delete();
      @(posedge clk); #2 rst = 1'b0;
      bus.DATA_IN    = 32'h12345678;
      bus.DATA_VALID = 1'b1;
      push6(SOF_P, 10'b0100111011, 10'b0010111001, 10'b0110100101, 10'b0011001100, EOF_N);
      wait_ready("post-reset DATA_READY", at);
      check("post-reset accept cycle", at, 32'd29);
      @(posedge clk); #1 bus.DATA_VALID = 1'b0;
      goto_cycle(100);
      check("post-reset WORD_CNT", {16'd0, wcnt}, 32'd1);
      check("post-reset drained", expq.size(), 32'd0);

      // WORD_CNT wrap on the inverted instance
      do_reset();
      #1 force dut_inv.word_cnt_q = 16'hFFFF;
      #1 release dut_inv.word_cnt_q;
      bus.DATA_IN    = 32'hDEADBEEF;
      bus.DATA_VALID = 1'b1;
      push6(SOF_P, 10'b0111100110, 10'b1011001010, 10'b1000011010, 10'b0101110001, EOF_N);
      @(negedge clk);
      check("preset WORD_CNT", {16'd0, wcnt_inv}, 32'h0000FFFF);
      wait_ready("wrap DATA_READY", at);
      check("wrap accept cycle", at, 32'd29);
      @(posedge clk); #1 bus.DATA_VALID = 1'b0;
      goto_cycle(100);
      check("wrapped WORD_CNT", {16'd0, wcnt_inv}, 32'd0);
      check("non-wrapped WORD_CNT", {16'd0, wcnt}, 32'd1);
      check("wrap drained", expq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
